// File: rtl/gardner_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gardner_lock_ctrl
// Brief    : Acquisition/tracking sequencer for the Gardner symbol-timing loop.
// Revision : 1.0 - initial release
// ============================================================================
module gardner_lock_ctrl #(
    parameter int ERR_W            = 16,
    parameter int WIN_LOG2         = 5,
    parameter int LOCK_THR         = 1024,
    parameter int UNLOCK_THR       = 4096,
    parameter int LOCK_WINS        = 4,
    parameter int UNLOCK_WINS      = 2,
    parameter int ACQ_TIMEOUT_WINS = 64,
    parameter int SYM_TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    sync_flag,
    input  logic signed [ERR_W-1:0] ted_err,
    output logic                    loop_clr,
    output logic                    loop_en,
    output logic                    gain_sel,
    output logic                    locked,
    output logic                    lock_lost,
    output logic [3:0]              acq_retries
);

    localparam int c_ACC_W  = ERR_W - 1 + WIN_LOG2;
    localparam int c_GOOD_W = $clog2(LOCK_WINS + 1);
    localparam int c_BAD_W  = $clog2(UNLOCK_WINS + 1);
    localparam int c_WIN_W  = $clog2(ACQ_TIMEOUT_WINS + 1);
    localparam int c_WD_W   = $clog2(SYM_TIMEOUT + 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_CLEAR = 2'd1;
    localparam logic [1:0] c_S_ACQ   = 2'd2;
    localparam logic [1:0] c_S_TRACK = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [c_ACC_W-1:0]  r_acc;
    logic [c_ACC_W-1:0]  w_sum;
    logic [c_ACC_W-1:0]  w_mean;
    logic [WIN_LOG2-1:0] r_smp;
    logic [c_GOOD_W-1:0] r_good;
    logic [c_GOOD_W-1:0] w_good_nxt;
    logic [c_BAD_W-1:0]  r_bad;
    logic [c_BAD_W-1:0]  w_bad_nxt;
    logic [c_WIN_W-1:0]  r_acq_win;
    logic [c_WIN_W-1:0]  w_acq_win_nxt;
    logic [c_WD_W-1:0]   r_wdog;
    logic [ERR_W-1:0]    w_neg;
    logic [ERR_W-2:0]    w_abs;
    logic                w_run;
    logic                w_win_end;
    logic                w_wdog_exp;

    always_comb begin
        w_neg = -ted_err;
        // The most negative error has no positive twin; clamp it to full scale.
        if (!ted_err[ERR_W-1])
            w_abs = ted_err[ERR_W-2:0];
        else if (ted_err == {1'b1, {(ERR_W-1){1'b0}}})
            w_abs = '1;
        else
            w_abs = w_neg[ERR_W-2:0];

        w_sum         = r_acc + c_ACC_W'(w_abs);
        w_mean        = w_sum >> WIN_LOG2;
        w_run         = (r_state == c_S_ACQ) || (r_state == c_S_TRACK);
        w_win_end     = w_run && sync_flag && (r_smp == '1);
        w_wdog_exp    = w_run && !sync_flag && (r_wdog == c_WD_W'(SYM_TIMEOUT - 1));
        w_good_nxt    = (w_mean < c_ACC_W'(LOCK_THR)) ? r_good + c_GOOD_W'(1) : '0;
        w_bad_nxt     = (w_mean >= c_ACC_W'(UNLOCK_THR)) ? r_bad + c_BAD_W'(1) : '0;
        w_acq_win_nxt = r_acq_win + c_WIN_W'(1);

        w_next = r_state;
        case (r_state)
            c_S_IDLE:  w_next = c_S_CLEAR;
            c_S_CLEAR: w_next = c_S_ACQ;
            c_S_ACQ: begin
                if (w_wdog_exp)
                    w_next = c_S_CLEAR;
                else if (w_win_end) begin
                    if (w_good_nxt == c_GOOD_W'(LOCK_WINS))
                        w_next = c_S_TRACK;
                    else if (w_acq_win_nxt == c_WIN_W'(ACQ_TIMEOUT_WINS))
                        w_next = c_S_CLEAR;
                end
            end
            default: begin
                if (w_wdog_exp || (w_win_end && (w_bad_nxt == c_BAD_W'(UNLOCK_WINS))))
                    w_next = c_S_CLEAR;
            end
        endcase
        if (!enable)
            w_next = c_S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_acc       <= '0;
            r_smp       <= '0;
            r_good      <= '0;
            r_bad       <= '0;
            r_acq_win   <= '0;
            r_wdog      <= '0;
            loop_clr    <= 1'b0;
            loop_en     <= 1'b0;
            gain_sel    <= 1'b0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            acq_retries <= 4'd0;
        end else begin
            r_state   <= w_next;
            loop_clr  <= (w_next == c_S_CLEAR);
            loop_en   <= (w_next == c_S_ACQ) || (w_next == c_S_TRACK);
            gain_sel  <= (w_next == c_S_TRACK);
            locked    <= (w_next == c_S_TRACK);
            lock_lost <= (r_state == c_S_TRACK) && (w_next == c_S_CLEAR);

            if (w_next == c_S_IDLE)
                acq_retries <= 4'd0;
            else if ((w_next == c_S_CLEAR) && (r_state != c_S_IDLE) && (acq_retries != 4'hF))
                acq_retries <= acq_retries + 4'd1;

            if (!w_run) begin
                r_acc     <= '0;
                r_smp     <= '0;
                r_good    <= '0;
                r_bad     <= '0;
                r_acq_win <= '0;
                r_wdog    <= '0;
            end else begin
                r_wdog <= sync_flag ? '0 : r_wdog + c_WD_W'(1);
                if (w_win_end) begin
                    r_acc <= '0;
                    r_smp <= '0;
                    if (r_state == c_S_ACQ) begin
                        r_good    <= w_good_nxt;
                        r_acq_win <= w_acq_win_nxt;
                    end else begin
                        r_bad <= w_bad_nxt;
                    end
                end else if (sync_flag) begin
                    r_acc <= w_sum;
                    r_smp <= r_smp + WIN_LOG2'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gardner_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gardner_lock_ctrl
// Brief    : Directed scoreboard bench for the Gardner lock sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gardner_lock_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               sync_flag;
    logic signed [15:0] ted_err;
    logic               loop_clr;
    logic               loop_en;
    logic               gain_sel;
    logic               locked;
    logic               lock_lost;
    logic [3:0]         acq_retries;

    int total = 0;
    int bad   = 0;

    logic [8:0] q_exp[$];
    string      q_tag[$];

    gardner_lock_ctrl #(
        .ERR_W(16), .WIN_LOG2(2), .LOCK_THR(1024), .UNLOCK_THR(4096),
        .LOCK_WINS(2), .UNLOCK_WINS(2), .ACQ_TIMEOUT_WINS(4), .SYM_TIMEOUT(16)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .sync_flag(sync_flag),
        .ted_err(ted_err), .loop_clr(loop_clr), .loop_en(loop_en),
        .gain_sel(gain_sel), .locked(locked), .lock_lost(lock_lost),
        .acq_retries(acq_retries)
    );

    always #5 clk = ~clk;

    // Output vector order: loop_clr, loop_en, gain_sel, locked, lock_lost, acq_retries
    function automatic logic [8:0] v(input logic c, input logic e, input logic g,
                                     input logic l, input logic ll, input int r);
        return {c, e, g, l, ll, 4'(r)};
    endfunction

    function automatic logic [8:0] acq(input int r);
        return v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, r);
    endfunction

    function automatic logic [8:0] trk(input int r);
        return v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, r);
    endfunction

    function automatic logic signed [15:0] alt(input int i);
        return (i % 2 == 1) ? 16'sd100 : -16'sd100;
    endfunction

    task automatic exp_next(input string tag, input logic [8:0] e);
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    task automatic tick();
        logic [8:0] obs;
        logic [8:0] e;
        string      t;
        @(posedge clk);
        #1;
        obs = {loop_clr, loop_en, gain_sel, locked, lock_lost, acq_retries};
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            total++;
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%b expected=%b", t, obs, e);
            end
        end
    endtask

    task automatic strobe(input string tag, input logic signed [15:0] err, input logic [8:0] e);
        sync_flag = 1'b1;
        ted_err   = err;
        exp_next(tag, e);
        tick();
        sync_flag = 1'b0;
    endtask

    task automatic gap(input string tag, input int n, input logic [8:0] e);
        for (int k = 0; k < n; k++) begin
            exp_next(tag, e);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "bench timeout");
    end

    initial begin
        int prev;
        int cur;
        rst = 1'b1; enable = 1'b0; sync_flag = 1'b0; ted_err = '0;

        exp_next("reset_idle", 9'd0);
        tick();
        enable = 1'b1;
        exp_next("reset_with_enable", 9'd0);
        tick();
        rst = 1'b0;
        exp_next("clear_pulse", v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        tick();
        exp_next("acq_entry", acq(0));
        tick();

        // Clean error: lock one cycle after the 8th strobe.
        for (int i = 1; i <= 8; i++) begin
            strobe("acquire", alt(i), (i == 8) ? trk(0) : acq(0));
            gap("acquire_gap", 7, (i == 8) ? trk(0) : acq(0));
        end

        // Mean just below the unlock threshold keeps lock.
        for (int i = 1; i <= 8; i++) begin
            strobe("hold_4095", 16'sd4095, trk(0));
            gap("hold_gap", 7, trk(0));
        end

        // Two bad windows at exactly the threshold drop lock.
        for (int i = 1; i <= 7; i++) begin
            strobe("unlock_pre", 16'sd4096, trk(0));
            gap("unlock_gap", 7, trk(0));
        end
        strobe("lock_lost", 16'sd4096, v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        exp_next("reacq", acq(1));
        tick();
        gap("reacq_gap", 6, acq(1));

        // A bad window in the middle resets the good-window run.
        for (int i = 1; i <= 16; i++) begin
            strobe("win_reset", (i > 4 && i <= 8) ? 16'sd2000 : alt(i),
                   (i == 16) ? trk(1) : acq(1));
            if (i < 16)
                gap("win_reset_gap", 7, acq(1));
        end

        // Strobe dropout while locked.
        gap("dropout_wait", 15, trk(1));
        exp_next("dropout", v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2));
        tick();
        exp_next("dropout_acq", acq(2));
        tick();
        gap("dropout_gap", 6, acq(2));

        // Acquisition timeouts, including the saturated-abs case and retry saturation.
        for (int r = 3; r <= 16; r++) begin
            prev = (r - 1 > 15) ? 15 : r - 1;
            cur  = (r > 15) ? 15 : r;
            for (int i = 1; i <= 16; i++) begin
                if (i < 16) begin
                    strobe("timeout_acq", (r == 4) ? -16'sd32768 : 16'sd5000, acq(prev));
                    gap("timeout_gap", 7, acq(prev));
                end else begin
                    strobe("timeout_clear", (r == 4) ? -16'sd32768 : 16'sd5000,
                           v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cur));
                end
            end
            exp_next("timeout_reacq", acq(cur));
            tick();
            gap("timeout_reacq_gap", 6, acq(cur));
        end

        for (int i = 1; i <= 8; i++) begin
            strobe("relock", alt(i), (i == 8) ? trk(15) : acq(15));
            gap("relock_gap", 7, (i == 8) ? trk(15) : acq(15));
        end

        // Disable while locked: straight to IDLE, retries cleared, strobes ignored.
        enable = 1'b0;
        exp_next("disable", 9'd0);
        tick();
        strobe("idle_strobe", 16'sd100, 9'd0);
        gap("idle_gap", 3, 9'd0);
        enable = 1'b1;
        exp_next("first_clear", v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        tick();

        // A strobe in the CLEAR cycle must not count toward the first window.
        strobe("clear_strobe", 16'sd100, acq(0));
        gap("clear_strobe_gap", 7, acq(0));
        for (int i = 1; i <= 8; i++) begin
            strobe("post_clear_lock", alt(i), (i == 8) ? trk(0) : acq(0));
            gap("post_clear_gap", 7, (i == 8) ? trk(0) : acq(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gardner_lock_ctrl.md
Name: gardner_lock_ctrl

Overview:
Acquisition/tracking sequencer for the Gardner symbol-timing loop (interpolator + TED + loop filter + NCO) in the QPSK demodulator. It watches the per-symbol timing error and the symbol strobe, and drives the loop-filter clear, enable and gain select. It declares lock and detects loss of lock. On acquisition timeout, loss of lock or a strobe dropout, it restarts acquisition.

Parameters:
ERR_W, 16, width of signed timing error ted_err
WIN_LOG2, 5, log2 of symbols per averaging window (32)
LOCK_THR, 1024, window mean |err| strictly below this counts as a good window
UNLOCK_THR, 4096, window mean |err| at or above this counts as a bad window (in TRACK)
LOCK_WINS, 4, consecutive good windows needed to declare lock
UNLOCK_WINS, 2, consecutive bad windows needed to drop lock
ACQ_TIMEOUT_WINS, 64, windows allowed in ACQ before retry
SYM_TIMEOUT, 64, clk cycles without sync_flag before dropout

Ports:
clk  in  1  system clock (500 kHz)
rst  in  1  synchronous reset, active-high
enable  in  1  run timing recovery; 0 forces IDLE
sync_flag  in  1  one-cycle symbol strobe from timing loop
ted_err  in  ERR_W  signed TED error, valid when sync_flag=1
loop_clr  out  1  one-cycle pulse that clears loop filter integrator and NCO
loop_en  out  1  loop filter update enable
gain_sel  out  1  0 = wide acquisition gains, 1 = narrow tracking gains
locked  out  1  lock status
lock_lost  out  1  one-cycle pulse on leaving TRACK for any reason other than enable=0
acq_retries  out  4  saturating count of CLEAR entries after the first; cleared in IDLE

Behaviour:
- Reset (rst=1 at a clk edge) puts the block in IDLE. All outputs are 0. All counters and the accumulator are 0.
- All outputs are registered.
- Priority at each edge: rst, then enable=0, then the watchdog, then window decisions.
- enable=0 in any state: next state is IDLE, with no loop_clr and no lock_lost pulse.
- |err| saturates: -2^(ERR_W-1) maps to 2^(ERR_W-1)-1.
- The accumulator is ERR_W-1+WIN_LOG2 bits. It cannot overflow, so it has no saturation.
- Window sample counter: counts sync_flag pulses in ACQ and TRACK.
- Window end: the cycle sync_flag=1 with sample count = 2^WIN_LOG2-1.
  - At window end, mean = (acc + |err|) >> WIN_LOG2, so the current sample is included.
  - The accumulator and sample counter then restart at 0.
- IDLE: loop_en=0, gain_sel=0, locked=0. enable=1 moves to CLEAR.
- CLEAR: lasts exactly 1 cycle, with loop_clr=1 and loop_en=0.
  - Clears the accumulator, sample, good, bad, window and watchdog counters.
  - acq_retries increments (saturating at 15) on every CLEAR entry except the first after IDLE.
  - Next state is ACQ.
- ACQ: loop_en=1, gain_sel=0, locked=0.
  - At window end: mean < LOCK_THR increments good_cnt; otherwise good_cnt resets to 0. acq_win_cnt increments either way.
  - When good_cnt reaches LOCK_WINS, next state is TRACK. locked and gain_sel rise the cycle after that window end.
  - Otherwise, when acq_win_cnt reaches ACQ_TIMEOUT_WINS, next state is CLEAR.
  - If both happen on the same window end, lock wins.
- TRACK: loop_en=1, gain_sel=1, locked=1.
  - At window end: mean >= UNLOCK_THR increments bad_cnt; otherwise bad_cnt resets to 0.
  - When bad_cnt reaches UNLOCK_WINS, lock_lost pulses for 1 cycle and next state is CLEAR.
  - locked falls in the same cycle lock_lost pulses.
- Watchdog (ACQ/TRACK only): the counter resets on every sync_flag.
  - When it reaches SYM_TIMEOUT, next state is CLEAR.
  - lock_lost pulses only if leaving TRACK.
- sync_flag outside ACQ/TRACK is ignored.
- sync_flag in the CLEAR cycle is discarded.
- Lock latency from ACQ entry with a clean error: LOCK_WINS·2^WIN_LOG2 strobes + 1 cycle.

Test Plan:
- Bench overrides: WIN_LOG2=2, LOCK_WINS=2, UNLOCK_WINS=2, ACQ_TIMEOUT_WINS=4, SYM_TIMEOUT=16, LOCK_THR=1024, UNLOCK_THR=4096. Strobe every 8 cycles unless noted.
- Reset/enable: rst=1, then enable=1 → all outputs 0 during reset; loop_clr=1 for exactly one cycle, then loop_en=1, gain_sel=0, acq_retries=0.
- Acquire: ted_err alternating ±100 for 8 strobes → locked=1 and gain_sel=1 exactly one cycle after the 8th strobe, no lock_lost.
- Window reset on bad window: ted_err=±100 for 4 strobes, 4 strobes of 2000, then 8 strobes of ±100 → locked rises only after strobe 16.
- Timeout retry: ted_err=5000 constantly → loop_clr every 16 strobes, acq_retries steps 1, 2, 3 …; driving ted_err=-32768 gives the same result (saturated abs).
- Loss of lock: after lock, ted_err=4096 for 8 strobes → lock_lost pulse, locked=0 and loop_clr on the next cycle; ted_err=4095 instead keeps locked=1.
- Dropout and enable: while locked, stop sync_flag → lock_lost and CLEAR 16 cycles after the last strobe. Deassert enable while locked → IDLE next cycle, no lock_lost, acq_retries=0.
